// File: rtl/spi_flash_responder_if.sv
// SPI host pad bundle between a flash host (master) and the flash responder (slave).
// Pure wiring; no latency and no flow control beyond the SPI clocking itself.
interface spi_flash_responder_if;
    logic spi_clk_i;
    logic spi_cs_ni;
    logic spi_mosi_i;
    logic spi_miso_o;
    logic spi_miso_en_o;

    modport master (
        output spi_clk_i, spi_cs_ni, spi_mosi_i,
        input  spi_miso_o, spi_miso_en_o
    );

    modport slave (
        input  spi_clk_i, spi_cs_ni, spi_mosi_i,
        output spi_miso_o, spi_miso_en_o
    );
endinterface

// File: rtl/spi_flash_responder.sv
// Mode-0 SPI flash device model oversampling the host pads; answers 9F/05/06/04/03/02 from an internal byte memory.
// Pad edges act SyncStages+1 clocks late, MISO moves one clock later; no backpressure, the host must clock slowly enough.
module spi_flash_responder #(
    parameter int unsigned MemDepth   = 256,
    parameter logic [23:0] JedecId    = 24'hEF4018,
    parameter int unsigned SyncStages = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    spi_flash_responder_if.slave  spi,
    output logic [7:0]            cmd_o,
    output logic                  cmd_valid_o,
    output logic                  wel_o
);
    localparam int unsigned AW = $clog2(MemDepth);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA_OUT, DATA_IN, IGNORE} state_t;

    logic [SyncStages-1:0] sck_sync, cs_sync, mosi_sync;
    logic                  sck_q, cs_q;

    // CS# sync resets low so a host already holding CS# low after reset does not look like a fresh fall.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sck_sync  <= '0;
            cs_sync   <= '0;
            mosi_sync <= '0;
            sck_q     <= 1'b0;
            cs_q      <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SyncStages-2:0], spi.spi_clk_i};
            cs_sync   <= {cs_sync[SyncStages-2:0], spi.spi_cs_ni};
            mosi_sync <= {mosi_sync[SyncStages-2:0], spi.spi_mosi_i};
            sck_q     <= sck_sync[SyncStages-1];
            cs_q      <= cs_sync[SyncStages-1];
        end
    end

    logic sck_s, cs_s, mosi_s;
    logic sck_rise, sck_fall, cs_fall;
    assign sck_s    = sck_sync[SyncStages-1];
    assign cs_s     = cs_sync[SyncStages-1];
    assign mosi_s   = mosi_sync[SyncStages-1];
    assign sck_rise = sck_s & ~sck_q;
    assign sck_fall = ~sck_s & sck_q;
    assign cs_fall  = ~cs_s & cs_q;

    state_t      state;
    logic [4:0]  bit_cnt;
    logic [6:0]  shreg;
    logic [7:0]  tx_byte;
    logic [23:0] addr;
    logic [1:0]  id_idx;
    logic        prog_seen;
    logic [7:0]  mem [MemDepth];

    logic [7:0]    rx_byte;
    logic [23:0]   addr_shift;
    logic [AW-1:0] rd_next;
    logic [7:0]    status;
    assign rx_byte    = {shreg, mosi_s};
    assign addr_shift = {addr[22:0], mosi_s};
    assign rd_next    = addr[AW-1:0] + AW'(1);
    assign status     = {6'b0, wel_o, 1'b0};

    function automatic logic [7:0] id_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    return JedecId[23:16];
            2'd1:    return JedecId[15:8];
            2'd2:    return JedecId[7:0];
            default: return 8'h00;
        endcase
    endfunction

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state             <= IDLE;
            bit_cnt           <= '0;
            shreg             <= '0;
            tx_byte           <= '0;
            addr              <= '0;
            id_idx            <= '0;
            prog_seen         <= 1'b0;
            cmd_o             <= 8'h00;
            cmd_valid_o       <= 1'b0;
            wel_o             <= 1'b0;
            spi.spi_miso_o    <= 1'b0;
            spi.spi_miso_en_o <= 1'b0;
            for (int i = 0; i < int'(MemDepth); i++) mem[i] <= 8'hFF;
        end else begin
            cmd_valid_o <= 1'b0;
            // A deasserted CS# outranks any SCK edge seen in the same cycle.
            if (cs_s) begin
                state             <= IDLE;
                bit_cnt           <= '0;
                shreg             <= '0;
                spi.spi_miso_o    <= 1'b0;
                spi.spi_miso_en_o <= 1'b0;
                if (prog_seen) begin
                    wel_o     <= 1'b0;
                    prog_seen <= 1'b0;
                end
            end else begin
                unique case (state)
                    IDLE: begin
                        if (cs_fall) begin
                            state   <= CMD;
                            bit_cnt <= '0;
                        end
                    end
                    CMD: begin
                        if (sck_rise) begin
                            shreg   <= rx_byte[6:0];
                            bit_cnt <= bit_cnt + 5'd1;
                            if (bit_cnt == 5'd7) begin
                                bit_cnt     <= '0;
                                cmd_o       <= rx_byte;
                                cmd_valid_o <= 1'b1;
                                case (rx_byte)
                                    8'h9F: begin
                                        state             <= DATA_OUT;
                                        spi.spi_miso_en_o <= 1'b1;
                                        tx_byte           <= id_byte(2'd0);
                                        id_idx            <= 2'd1;
                                    end
                                    8'h05: begin
                                        state             <= DATA_OUT;
                                        spi.spi_miso_en_o <= 1'b1;
                                        tx_byte           <= status;
                                    end
                                    8'h06: begin
                                        wel_o <= 1'b1;
                                        state <= IGNORE;
                                    end
                                    8'h04: begin
                                        wel_o <= 1'b0;
                                        state <= IGNORE;
                                    end
                                    8'h03: state <= ADDR;
                                    8'h02: begin
                                        state     <= ADDR;
                                        prog_seen <= 1'b1;
                                    end
                                    default: state <= IGNORE;
                                endcase
                            end
                        end
                    end
                    ADDR: begin
                        if (sck_rise) begin
                            addr    <= addr_shift;
                            bit_cnt <= bit_cnt + 5'd1;
                            if (bit_cnt == 5'd23) begin
                                bit_cnt <= '0;
                                if (cmd_o == 8'h03) begin
                                    state             <= DATA_OUT;
                                    spi.spi_miso_en_o <= 1'b1;
                                    tx_byte           <= mem[addr_shift[AW-1:0]];
                                end else if (wel_o) begin
                                    state <= DATA_IN;
                                end else begin
                                    state <= IGNORE;
                                end
                            end
                        end
                    end
                    DATA_OUT: begin
                        if (sck_fall) begin
                            spi.spi_miso_o <= tx_byte[7];
                            tx_byte        <= {tx_byte[6:0], 1'b0};
                            bit_cnt        <= bit_cnt + 5'd1;
                            // After bit 0 leaves, preload the next byte so its bit 7 goes on the next fall.
                            if (bit_cnt[2:0] == 3'd7) begin
                                bit_cnt <= '0;
                                case (cmd_o)
                                    8'h9F: begin
                                        tx_byte <= id_byte(id_idx);
                                        if (id_idx != 2'd3) id_idx <= id_idx + 2'd1;
                                    end
                                    8'h05: tx_byte <= status;
                                    default: begin
                                        tx_byte <= mem[rd_next];
                                        addr    <= addr + 24'd1;
                                    end
                                endcase
                            end
                        end
                    end
                    DATA_IN: begin
                        if (sck_rise) begin
                            shreg   <= rx_byte[6:0];
                            bit_cnt <= bit_cnt + 5'd1;
                            if (bit_cnt == 5'd7) begin
                                bit_cnt               <= '0;
                                mem[addr[AW-1:0]]     <= mem[addr[AW-1:0]] & rx_byte;
                                addr                  <= addr + 24'd1;
                            end
                        end
                    end
                    IGNORE: ;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spi_flash_responder.sv
// Bench for spi_flash_responder: a table of flash transactions with a byte scoreboard, plus abort/partial/reset sequences.
module tb_spi_flash_responder;
    localparam int HALF = 8;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic [7:0] cmd_o;
    logic       cmd_valid_o;
    logic       wel_o;

    spi_flash_responder_if spi ();

    spi_flash_responder #(
        .MemDepth   (256),
        .JedecId    (24'hEF4018),
        .SyncStages (2)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .spi         (spi.slave),
        .cmd_o       (cmd_o),
        .cmd_valid_o (cmd_valid_o),
        .wel_o       (wel_o)
    );

    always #5 clk_i = ~clk_i;

    int pulses = 0;
    always @(posedge clk_i) if (cmd_valid_o === 1'b1) pulses <= pulses + 1;

    typedef struct {
        logic [7:0]  cmd;
        bit          has_addr;
        logic [23:0] addr;
        int          nwr;
        logic [15:0] wr;
        int          nrd;
        logic [39:0] rd;
        logic        wel;
    } vec_t;

    localparam int NV = 17;
    vec_t       vecs [NV];
    logic [7:0] exp_q [$];
    int         checks   = 0;
    int         failures = 0;
    int         en_err   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic cs_fall();
        spi.spi_cs_ni = 1'b0;
        wait_cyc(HALF);
    endtask

    task automatic cs_rise();
        wait_cyc(HALF);
        spi.spi_cs_ni = 1'b1;
        wait_cyc(2 * HALF);
    endtask

    // Host samples MISO just before raising SCK; MISO enable is checked at the same point.
    task automatic xfer(input logic [7:0] tx, input int nbits, input logic exp_en, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            spi.spi_mosi_i = tx[i];
            wait_cyc(HALF);
            rx[i] = spi.spi_miso_o;
            if (spi.spi_miso_en_o !== exp_en) en_err++;
            spi.spi_clk_i = 1'b1;
            wait_cyc(HALF);
            spi.spi_clk_i = 1'b0;
        end
    endtask

    task automatic run_row(input vec_t t);
        logic [7:0] rx;
        logic [7:0] exp_b;
        int         mark;
        en_err = 0;
        mark   = pulses;
        cs_fall();
        xfer(t.cmd, 8, 1'b0, rx);
        if (t.has_addr) begin
            xfer(t.addr[23:16], 8, 1'b0, rx);
            xfer(t.addr[15:8],  8, 1'b0, rx);
            xfer(t.addr[7:0],   8, 1'b0, rx);
        end
        for (int w = 0; w < t.nwr; w++) xfer(t.wr[15-8*w -: 8], 8, 1'b0, rx);
        for (int r = 0; r < t.nrd; r++) exp_q.push_back(t.rd[39-8*r -: 8]);
        for (int r = 0; r < t.nrd; r++) begin
            xfer(8'h00, 8, 1'b1, rx);
            exp_b = exp_q.pop_front();
            chk($sformatf("rd_byte cmd=%h n=%0d", t.cmd, r), {24'h0, rx}, {24'h0, exp_b});
        end
        cs_rise();
        chk($sformatf("cmd_o cmd=%h", t.cmd), {24'h0, cmd_o}, {24'h0, t.cmd});
        chk($sformatf("cmd_valid_pulses cmd=%h", t.cmd), pulses - mark, 1);
        chk($sformatf("wel cmd=%h", t.cmd), {31'h0, wel_o}, {31'h0, t.wel});
        chk($sformatf("miso_en_phase cmd=%h", t.cmd), en_err, 0);
        chk($sformatf("miso_en_idle cmd=%h", t.cmd), {31'h0, spi.spi_miso_en_o}, 32'h0);
    endtask

    initial begin
        logic [7:0] rx;
        vecs[0]  = '{8'h03, 1'b1, 24'h000000, 0, 16'h0000, 4, 40'hFFFFFFFF00, 1'b0};
        vecs[1]  = '{8'h9F, 1'b0, 24'h000000, 0, 16'h0000, 5, 40'hEF40180000, 1'b0};
        vecs[2]  = '{8'h06, 1'b0, 24'h000000, 0, 16'h0000, 0, 40'h0,          1'b1};
        vecs[3]  = '{8'h02, 1'b1, 24'h000010, 2, 16'hA53C, 0, 40'h0,          1'b0};
        vecs[4]  = '{8'h03, 1'b1, 24'h000010, 0, 16'h0000, 3, 40'hA53CFF0000, 1'b0};
        vecs[5]  = '{8'h06, 1'b0, 24'h000000, 0, 16'h0000, 0, 40'h0,          1'b1};
        vecs[6]  = '{8'h02, 1'b1, 24'h000010, 1, 16'h0F00, 0, 40'h0,          1'b0};
        vecs[7]  = '{8'h03, 1'b1, 24'h000010, 0, 16'h0000, 1, 40'h0500000000, 1'b0};
        vecs[8]  = '{8'h02, 1'b1, 24'h000020, 1, 16'h0000, 0, 40'h0,          1'b0};
        vecs[9]  = '{8'h03, 1'b1, 24'h000020, 0, 16'h0000, 1, 40'hFF00000000, 1'b0};
        vecs[10] = '{8'h06, 1'b0, 24'h000000, 0, 16'h0000, 0, 40'h0,          1'b1};
        vecs[11] = '{8'h02, 1'b1, 24'h0000FF, 2, 16'h1234, 0, 40'h0,          1'b0};
        vecs[12] = '{8'h03, 1'b1, 24'hFFFFFF, 0, 16'h0000, 2, 40'h1234000000, 1'b0};
        vecs[13] = '{8'h06, 1'b0, 24'h000000, 0, 16'h0000, 0, 40'h0,          1'b1};
        vecs[14] = '{8'h05, 1'b0, 24'h000000, 0, 16'h0000, 2, 40'h0202000000, 1'b1};
        vecs[15] = '{8'h04, 1'b0, 24'h000000, 0, 16'h0000, 0, 40'h0,          1'b0};
        vecs[16] = '{8'h05, 1'b0, 24'h000000, 0, 16'h0000, 1, 40'h0000000000, 1'b0};

        spi.spi_clk_i  = 1'b0;
        spi.spi_cs_ni  = 1'b1;
        spi.spi_mosi_i = 1'b0;
        rst_i = 1'b1;
        wait_cyc(5);
        rst_i = 1'b0;
        wait_cyc(5);
        chk("reset miso",      {31'h0, spi.spi_miso_o},    32'h0);
        chk("reset miso_en",   {31'h0, spi.spi_miso_en_o}, 32'h0);
        chk("reset cmd_o",     {24'h0, cmd_o},             32'h0);
        chk("reset cmd_valid", {31'h0, cmd_valid_o},       32'h0);
        chk("reset wel",       {31'h0, wel_o},             32'h0);

        for (int v = 0; v < NV; v++) run_row(vecs[v]);

        // Abort a read after 12 address bits, then the ID must still come back intact.
        cs_fall();
        xfer(8'h03, 8, 1'b0, rx);
        xfer(8'h00, 8, 1'b0, rx);
        xfer(8'hF0, 4, 1'b0, rx);
        cs_rise();
        chk("abort miso_en", {31'h0, spi.spi_miso_en_o}, 32'h0);
        run_row(vecs[1]);

        // Program with only 5 data bits: nothing written, latch still cleared.
        run_row(vecs[2]);
        cs_fall();
        xfer(8'h02, 8, 1'b0, rx);
        xfer(8'h00, 8, 1'b0, rx);
        xfer(8'h00, 8, 1'b0, rx);
        xfer(8'h30, 8, 1'b0, rx);
        xfer(8'h00, 5, 1'b0, rx);
        cs_rise();
        chk("partial wel", {31'h0, wel_o}, 32'h0);
        run_row('{8'h03, 1'b1, 24'h000030, 0, 16'h0000, 1, 40'hFF00000000, 1'b0});

        // Reset in the middle of a read: outputs and memory return to reset values.
        run_row(vecs[2]);
        cs_fall();
        xfer(8'h03, 8, 1'b0, rx);
        xfer(8'h00, 8, 1'b0, rx);
        rst_i = 1'b1;
        wait_cyc(3);
        chk("midrst wel",     {31'h0, wel_o},             32'h0);
        chk("midrst cmd_o",   {24'h0, cmd_o},             32'h0);
        chk("midrst miso_en", {31'h0, spi.spi_miso_en_o}, 32'h0);
        rst_i = 1'b0;
        wait_cyc(3);
        xfer(8'h00, 8, 1'b0, rx);
        xfer(8'h10, 8, 1'b0, rx);
        xfer(8'h00, 8, 1'b0, rx);
        cs_rise();
        chk("midrst ignored cmd_o", {24'h0, cmd_o}, 32'h0);
        run_row('{8'h03, 1'b1, 24'h000010, 0, 16'h0000, 2, 40'hFFFF000000, 1'b0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
